// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS software-written 32-bit control
// registers for Simulink user logic. Each register has an OPB-visible shadow
// copy and a user-visible active copy. In immediate mode a write lands in both
// at once; in sync mode writes collect in the shadow and move to the active
// copy together on a user_sync pulse. Pulse-masked registers self-clear one
// cycle after they are loaded.
module opb_register_bank_ppc2simulink #(
   parameter logic [31:0]           C_BASEADDR   = 32'h0100E200,
   parameter logic [31:0]           C_HIGHADDR   = 32'h0100E2FF,
   parameter int                    C_OPB_AWIDTH = 32,
   parameter int                    C_OPB_DWIDTH = 32,
   parameter int                    C_NUM_REGS   = 4,
   parameter int                    C_SYNC_MODE  = 0,
   parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
   parameter logic [31:0]           C_RESET_VAL  = '0,
   parameter                        C_FAMILY     = "virtex6"
) (
   input  logic                       OPB_Clk,
   input  logic                       OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
   input  logic [0:3]                 OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
   input  logic                       OPB_RNW,
   input  logic                       OPB_select,
   input  logic                       OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
   output logic                       Sl_errAck,
   output logic                       Sl_retry,
   output logic                       Sl_toutSup,
   output logic                       Sl_xferAck,
   input  logic                       user_sync,
   output logic [32*C_NUM_REGS-1:0]   user_data_out,
   output logic [C_NUM_REGS-1:0]      user_wr_stb,
   output logic                       commit_pending
);

   localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_WAIT
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Bus decode. Declaring the OPB vectors [0:31] makes DBus[31] the user LSB,
   // so a plain assignment gives user bit i = DBus[31-i] and BE[0] = byte 3.
   logic [31:0]             w_addr;
   logic [31:0]             w_offset;
   logic [31:0]             w_wdata;
   logic [3:0]              w_be;
   logic [31:0]             w_be_mask;
   logic                    w_hit;
   logic                    w_valid;
   logic [IW-1:0]           w_idx;

   // Transfer attributes captured when the hit is accepted.
   logic                    r_rnw;
   logic                    r_valid;
   logic [IW-1:0]           r_idx;

   logic                    w_ack;
   logic                    w_wr;
   logic                    w_commit;
   logic [C_NUM_REGS-1:0]   w_wr_vec;
   logic [C_NUM_REGS-1:0]   w_load_vec;
   logic [C_NUM_REGS-1:0]   w_clr_vec;
   logic [31:0]             w_wr_base;
   logic [31:0]             w_wr_merged;

   logic [C_NUM_REGS-1:0]   r_dirty;
   logic [C_NUM_REGS-1:0]   r_stb;

   logic [C_NUM_REGS-1:0][31:0] w_shadow;
   logic [C_NUM_REGS-1:0][31:0] w_active;

   logic                    w_unused;

   assign w_addr   = OPB_ABus;
   assign w_wdata  = OPB_DBus;
   assign w_be     = OPB_BE;
   assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
   assign w_offset = w_addr - C_BASEADDR;
   assign w_valid  = (w_offset[31:2] < 30'(C_NUM_REGS));
   assign w_idx    = w_offset[IW+1:2];

   // Sequential-burst hint, low address bits and family name carry no meaning here.
   assign w_unused = ^{OPB_seqAddr, w_offset[1:0], C_FAMILY};

   // Expand byte enables into a bit mask over the user-ordered word.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_be_mask = '0;
      for (int b = 0; b < 4; b++) begin
         w_be_mask[8*b +: 8] = {8{w_be[b]}};
      end
   end

   // Handshake state register and captured transfer attributes.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         r_state <= ST_IDLE;
         r_rnw   <= 1'b0;
         r_valid <= 1'b0;
         r_idx   <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge
         // values, so register order inside the block does not matter.
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_hit) begin
            r_rnw   <= OPB_RNW;
            r_valid <= w_valid;
            r_idx   <= w_idx;
         end
      end
   end

   // Next state: one ack per select; WAIT holds until the master drops select.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_hit)       w_state_nxt = ST_ACK;
         ST_ACK:                   w_state_nxt = ST_WAIT;
         ST_WAIT: if (!OPB_select) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_ack      = (r_state == ST_ACK);
   assign w_wr       = w_ack && !r_rnw && r_valid;
   assign Sl_xferAck = w_ack;
   assign Sl_errAck  = w_ack && !r_valid;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // Read mux: shadow contents (uncommitted data included), zero otherwise.
   always_comb begin
      Sl_DBus = '0;
      if (w_ack && r_rnw && r_valid) begin
         Sl_DBus = w_shadow[r_idx];
      end
   end

   // Per-register write, load and self-clear decisions.
   always_comb begin
      w_wr_vec = '0;
      if (w_wr) begin
         w_wr_vec[r_idx] = 1'b1;
      end
      w_commit   = (C_SYNC_MODE != 0) && user_sync && (|r_dirty);
      w_load_vec = (C_SYNC_MODE != 0) ? (w_commit ? r_dirty : '0) : w_wr_vec;
      w_clr_vec  = C_PULSE_MASK & r_stb;
      // A write landing on a register that is self-clearing this cycle merges
      // onto zero, so the unwritten bytes do not resurrect the old pulse.
      w_wr_base   = w_clr_vec[r_idx] ? 32'h0 : w_shadow[r_idx];
      w_wr_merged = (w_wr_base & ~w_be_mask) | (w_wdata & w_be_mask);
   end

   // Dirty tracking and update strobes. A commit clears what it moved; a write
   // in the same cycle re-marks its register for the next sync.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         r_dirty <= '0;
         r_stb   <= '0;
      end else begin
         r_dirty <= (C_SYNC_MODE != 0) ? ((r_dirty & ~w_load_vec) | w_wr_vec) : '0;
         r_stb   <= w_load_vec;
      end
   end

   for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg
      logic [31:0] r_shadow;
      logic [31:0] r_active;

      // Shadow takes bus writes; active takes the shadow on load; pulse bits clear both.
      always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
         if (OPB_Rst) begin
            // NOTE: the register file is small and its contents are visible to
            // user logic, so every entry is reset rather than left undefined.
            r_shadow <= C_RESET_VAL;
            r_active <= C_RESET_VAL;
         end else begin
            if (w_wr_vec[k]) begin
               r_shadow <= w_wr_merged;
            end else if (w_clr_vec[k]) begin
               r_shadow <= '0;
            end
            if (w_load_vec[k]) begin
               r_active <= (C_SYNC_MODE != 0) ? r_shadow : w_wr_merged;
            end else if (w_clr_vec[k]) begin
               r_active <= '0;
            end
         end
      end

      assign w_shadow[k] = r_shadow;
      assign w_active[k] = r_active;
   end

   assign user_data_out  = w_active;
   assign user_wr_stb    = r_stb;
   assign commit_pending = |r_dirty;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench: an immediate-mode bank (reg 2 pulse-masked) and a sync-mode bank with
// a non-zero reset value share one OPB bus at different base addresses.
module tb_opb_register_bank_ppc2simulink;

   localparam logic [31:0] BASE_I = 32'h0100E200;
   localparam logic [31:0] BASE_S = 32'h0100E300;
   localparam logic [31:0] RV     = 32'h5A5A0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [0:31]   opb_abus = '0;
   logic [0:3]    opb_be = '0;
   logic [0:31]   opb_dbus = '0;
   logic          opb_rnw = 1'b0;
   logic          opb_sel = 1'b0;
   logic          opb_seq = 1'b0;
   logic          user_sync = 1'b0;

   logic [0:31]   dbus_i, dbus_s;
   logic          err_i, err_s, ack_i, ack_s;
   logic          retry_i, retry_s, tout_i, tout_s;
   logic [127:0]  udo_i, udo_s;
   logic [3:0]    stb_i, stb_s;
   logic          pend_i, pend_s;

   int n_total = 0;
   int n_bad   = 0;
   int cnt_i[4] = '{0, 0, 0, 0};
   int cnt_s[4] = '{0, 0, 0, 0};
   int pulse_cycles = 0;
   logic [31:0] pulse_val = '0;

   always #5 clk = ~clk;

   opb_register_bank_ppc2simulink #(
      .C_BASEADDR(BASE_I), .C_HIGHADDR(32'h0100E2FF), .C_NUM_REGS(4),
      .C_SYNC_MODE(0), .C_PULSE_MASK(4'b0100), .C_RESET_VAL(32'h0)
   ) u_imm (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(opb_abus), .OPB_BE(opb_be),
      .OPB_DBus(opb_dbus), .OPB_RNW(opb_rnw), .OPB_select(opb_sel),
      .OPB_seqAddr(opb_seq), .Sl_DBus(dbus_i), .Sl_errAck(err_i),
      .Sl_retry(retry_i), .Sl_toutSup(tout_i), .Sl_xferAck(ack_i),
      .user_sync(user_sync), .user_data_out(udo_i), .user_wr_stb(stb_i),
      .commit_pending(pend_i)
   );

   opb_register_bank_ppc2simulink #(
      .C_BASEADDR(BASE_S), .C_HIGHADDR(32'h0100E3FF), .C_NUM_REGS(4),
      .C_SYNC_MODE(1), .C_PULSE_MASK(4'b0000), .C_RESET_VAL(RV)
   ) u_sync (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(opb_abus), .OPB_BE(opb_be),
      .OPB_DBus(opb_dbus), .OPB_RNW(opb_rnw), .OPB_select(opb_sel),
      .OPB_seqAddr(opb_seq), .Sl_DBus(dbus_s), .Sl_errAck(err_s),
      .Sl_retry(retry_s), .Sl_toutSup(tout_s), .Sl_xferAck(ack_s),
      .user_sync(user_sync), .user_data_out(udo_s), .user_wr_stb(stb_s),
      .commit_pending(pend_s)
   );

   // Strobe counters and pulse-register observer, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            cnt_i[k] += int'(stb_i[k]);
            cnt_s[k] += int'(stb_s[k]);
         end
         if (udo_i[95:64] != 32'h0) begin
            pulse_cycles++;
            pulse_val = udo_i[95:64];
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete OPB transfer; optionally raises user_sync during the ack cycle.
   task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input logic sync_in_ack,
                       output logic got_ack, output logic got_err,
                       output logic [31:0] rdata, output int lat);
      got_ack = 1'b0;
      got_err = 1'b0;
      rdata   = '0;
      lat     = -1;
      @(posedge clk); #1;
      opb_abus = addr;
      opb_be   = be;
      opb_dbus = data;
      opb_rnw  = rnw;
      opb_sel  = 1'b1;
      for (int i = 0; i < 8 && !got_ack; i++) begin
         @(negedge clk);
         if (ack_i || ack_s) begin
            got_ack = 1'b1;
            got_err = err_i | err_s;
            rdata   = dbus_i | dbus_s;
            lat     = i;
            if (sync_in_ack) user_sync = 1'b1;
         end
      end
      @(posedge clk); #1;
      opb_sel   = 1'b0;
      opb_rnw   = 1'b0;
      user_sync = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic sync_pulse(output logic [3:0] stb_seen);
      @(posedge clk); #1;
      user_sync = 1'b1;
      @(posedge clk); #1;
      user_sync = 1'b0;
      @(negedge clk);
      stb_seen = stb_s;
   endtask

   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic        a, e;
      logic [31:0] rd;
      int          lat;
      logic [3:0]  stb_seen;
      int          c0, c2, acks;

      tbl[0]  = '{1'b1, BASE_I + 32'h08, 4'hF, 32'h0,        1'b0, 32'h0};
      tbl[1]  = '{1'b0, BASE_I + 32'h04, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, BASE_I + 32'h04, 4'h1, 32'h00000012, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, BASE_I + 32'h04, 4'h0, 32'h0,        1'b0, 32'hDEADBE12};
      tbl[4]  = '{1'b0, BASE_I + 32'h00, 4'hA, 32'hA5A5A5A5, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, BASE_I + 32'h00, 4'hF, 32'h0,        1'b0, 32'hA500A500};
      tbl[6]  = '{1'b0, BASE_I + 32'h0C, 4'h0, 32'h12345678, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, BASE_I + 32'h0C, 4'hF, 32'h0,        1'b0, 32'h0};
      tbl[8]  = '{1'b0, BASE_I + 32'h40, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
      tbl[9]  = '{1'b1, BASE_I + 32'h40, 4'hF, 32'h0,        1'b1, 32'h0};
      tbl[10] = '{1'b1, BASE_I + 32'h10, 4'hF, 32'h0,        1'b1, 32'h0};
      tbl[11] = '{1'b1, BASE_I + 32'hFC, 4'hF, 32'h0,        1'b1, 32'h0};
      tbl[12] = '{1'b0, BASE_I + 32'h0C, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
      tbl[13] = '{1'b1, BASE_I + 32'h0C, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
      tbl[14] = '{1'b1, BASE_I + 32'h00, 4'h0, 32'h0,        1'b0, 32'hA500A500};

      // Reset state
      #12;
      check("rst_ack", {ack_i, ack_s, err_i, err_s}, 4'b0);
      check("rst_dbus", {dbus_i, dbus_s}, 64'h0);
      check("rst_udo_imm", udo_i, 128'h0);
      check("rst_udo_sync", udo_s, {4{RV}});
      check("rst_pend", {pend_i, pend_s, stb_i, stb_s}, 10'h0);
      check("rst_tied", {retry_i, retry_s, tout_i, tout_s}, 4'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Immediate-mode table
      for (int i = 0; i < 15; i++) begin
         xfer(tbl[i].rnw, tbl[i].addr, tbl[i].be, tbl[i].wdata, 1'b0, a, e, rd, lat);
         check($sformatf("vec%0d_ack", i), a, 1'b1);
         check($sformatf("vec%0d_lat", i), lat, 1);
         check($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      end
      check("imm_udo", udo_i, {32'hCAFEF00D, 32'h0, 32'hDEADBE12, 32'hA500A500});
      check("imm_stb_cnt", {cnt_i[3][7:0], cnt_i[2][7:0], cnt_i[1][7:0], cnt_i[0][7:0]},
            32'h02_00_02_01);
      check("imm_sync_untouched", udo_s, {4{RV}});
      check("imm_pend", pend_i, 1'b0);

      // Address outside both windows: no ack
      xfer(1'b1, 32'h01000000, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("miss_noack", a, 1'b0);

      // Pulse-masked register 2
      pulse_cycles = 0;
      c2 = cnt_i[2];
      xfer(1'b0, BASE_I + 32'h08, 4'hF, 32'h00000001, 1'b0, a, e, rd, lat);
      repeat (2) @(posedge clk);
      #1;
      check("pulse_cycles", pulse_cycles, 1);
      check("pulse_val", pulse_val, 32'h1);
      check("pulse_stb", cnt_i[2] - c2, 1);
      check("pulse_active_after", udo_i[95:64], 32'h0);
      xfer(1'b1, BASE_I + 32'h08, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("pulse_readback", {a, rd}, {1'b1, 32'h0});

      // Sync mode: two writes, then a single commit
      xfer(1'b1, BASE_S + 32'h08, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("sync_rd_rv", {a, e, rd}, {2'b10, RV});
      xfer(1'b0, BASE_S + 32'h00, 4'hF, 32'h11, 1'b0, a, e, rd, lat);
      xfer(1'b0, BASE_S + 32'h0C, 4'hF, 32'h33, 1'b0, a, e, rd, lat);
      check("sync_hold_udo", udo_s, {4{RV}});
      check("sync_pend1", pend_s, 1'b1);
      xfer(1'b1, BASE_S + 32'h00, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("sync_rd_shadow", rd, 32'h11);
      sync_pulse(stb_seen);
      check("sync_stb_1001", stb_seen, 4'b1001);
      check("sync_udo1", udo_s, {32'h33, RV, RV, 32'h11});
      check("sync_pend0", pend_s, 1'b0);

      // Sync mode: write in the same cycle as user_sync
      xfer(1'b0, BASE_S + 32'h00, 4'hF, 32'h22, 1'b0, a, e, rd, lat);
      c0 = cnt_s[0];
      c2 = cnt_s[2];
      xfer(1'b0, BASE_S + 32'h08, 4'hF, 32'h44, 1'b1, a, e, rd, lat);
      check("coll_udo", udo_s, {32'h33, RV, RV, 32'h22});
      check("coll_stb", {cnt_s[0] - c0, cnt_s[2] - c2}, {32'd1, 32'd0});
      check("coll_pend", pend_s, 1'b1);
      sync_pulse(stb_seen);
      check("coll_stb2", stb_seen, 4'b0100);
      check("coll_udo2", udo_s, {32'h33, 32'h44, RV, 32'h22});
      sync_pulse(stb_seen);
      check("idle_sync_stb", stb_seen, 4'b0000);
      check("idle_sync_udo", udo_s, {32'h33, 32'h44, RV, 32'h22});

      // Partial write in sync mode reads back through the shadow
      xfer(1'b0, BASE_S + 32'h04, 4'h1, 32'h000000FF, 1'b0, a, e, rd, lat);
      xfer(1'b1, BASE_S + 32'h04, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("sync_partial_rd", rd, 32'h5A5A00FF);
      check("sync_partial_udo", udo_s[63:32], RV);

      // Reset asserted during an ack cycle
      @(posedge clk); #1;
      opb_abus = BASE_I + 32'h04;
      opb_be   = 4'hF;
      opb_dbus = 32'h77777777;
      opb_rnw  = 1'b0;
      opb_sel  = 1'b1;
      a = 1'b0;
      for (int i = 0; i < 4 && !a; i++) begin
         @(negedge clk);
         a = ack_i;
      end
      check("rstack_seen", a, 1'b1);
      rst = 1'b1;
      #1;
      check("rstack_ack", {ack_i, err_i, dbus_i}, 34'h0);
      check("rstack_udo_imm", udo_i, 128'h0);
      check("rstack_udo_sync", udo_s, {4{RV}});
      check("rstack_pend_stb", {pend_s, stb_i, stb_s}, 9'h0);
      @(posedge clk); #1;
      opb_sel = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      xfer(1'b1, BASE_I + 32'h04, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("rstack_aborted", {a, rd}, {1'b1, 32'h0});
      xfer(1'b1, BASE_S + 32'h04, 4'hF, 32'h0, 1'b0, a, e, rd, lat);
      check("rstack_sync_rv", rd, RV);

      // Select held for several cycles: exactly one ack
      @(posedge clk); #1;
      opb_abus = BASE_I;
      opb_rnw  = 1'b1;
      opb_sel  = 1'b1;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         acks += int'(ack_i);
      end
      @(posedge clk); #1;
      opb_sel = 1'b0;
      opb_rnw = 1'b0;
      repeat (2) @(posedge clk);
      check("hold_one_ack", acks, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
